// File: rtl/dispatch_credit_router.sv
// dispatch_credit_router
//   Dispatch stage between the decode skid buffer and NUM_RS reservation
//   stations plus the ROB. Each decoded instruction is routed to one RS by
//   index and receives a ROB tag from an internal tail counter. Credit
//   counters track free RS and ROB entries so neither ever sees an
//   allocation it cannot absorb. Outputs are registered, one-cycle latency.
//   Default channel map: 0=ALU, 1=BRANCH, 2=LSU.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   i_valid         skid buffer holds an instruction
//   o_ready         dispatch accepts this cycle (combinational)
//   i_rs_sel        target RS index
//   i_pc, i_payload instruction PC and decoded fields (passed through)
//   i_rs_free       per-RS pulse: one RS entry freed
//   i_rob_commit    pulse: ROB retired one entry
//   i_flush         backend flush: clears credits, occupancy and tail
//   o_alloc_rs      one-hot RS write strobe (1 cycle)
//   o_alloc_rob     ROB allocate strobe (1 cycle)
//   o_pc, o_payload registered PC / payload of the dispatched instruction
//   o_rob_tag       ROB tag of the dispatched instruction
//   o_rob_count     current ROB occupancy
//   o_illegal       i_valid with an out-of-range i_rs_sel (combinational)

module dispatch_credit_router #(
    parameter int NUM_RS    = 3,
    parameter int RS_DEPTH  = 8,
    parameter int ROB_DEPTH = 16,
    parameter int PC_W      = 9,
    parameter int PAYLOAD_W = 64,
    parameter int SEL_W     = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SEL_W-1:0]     i_rs_sel,
    input  logic [PC_W-1:0]      i_pc,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic [NUM_RS-1:0]    i_rs_free,
    input  logic                 i_rob_commit,
    input  logic                 i_flush,
    output logic [NUM_RS-1:0]    o_alloc_rs,
    output logic                 o_alloc_rob,
    output logic [PC_W-1:0]      o_pc,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [TAG_W-1:0]     o_rob_tag,
    output logic [TAG_W:0]       o_rob_count,
    output logic                 o_illegal
);

    localparam int                CRED_W   = $clog2(RS_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RS_DEPTH);
    localparam logic [TAG_W:0]    ROB_FULL = (TAG_W + 1)'(ROB_DEPTH);

    logic [CRED_W-1:0] credits [NUM_RS];
    logic [TAG_W:0]    rob_count;
    logic [TAG_W-1:0]  tail;

    logic              sel_ok;
    logic              credit_ok;
    logic              accept;
    logic [NUM_RS-1:0] sel_onehot;
    logic [NUM_RS-1:0] cred_inc;
    logic [NUM_RS-1:0] cred_dec;
    logic              commit_ok;

    // Channel decode and readiness. Selecting the credit through a loop keeps
    // an out-of-range index from ever addressing the credit array.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_ok     = ({1'b0, i_rs_sel} < (SEL_W + 1)'(NUM_RS));
        credit_ok  = 1'b0;
        sel_onehot = '0;
        cred_inc   = '0;
        cred_dec   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (sel_ok && (i_rs_sel == SEL_W'(k))) begin
                sel_onehot[k] = 1'b1;
                credit_ok     = (credits[k] != '0);
            end
        end
        o_ready   = !i_flush && sel_ok && credit_ok && (rob_count != ROB_FULL);
        o_illegal = i_valid && !sel_ok;
        accept    = i_valid && o_ready;
        // A free arriving when the RS is already fully credited is spurious
        // and dropped; a simultaneous take and free cancel out.
        for (int k = 0; k < NUM_RS; k++) begin
            cred_inc[k] = i_rs_free[k] && (credits[k] != CRED_MAX);
            cred_dec[k] = accept && sel_onehot[k];
        end
        commit_ok = i_rob_commit && (rob_count != '0);
    end

    assign o_rob_count = rob_count;

    // Output register: strobes pulse for one cycle, data holds between accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_alloc_rs  <= '0;
            o_alloc_rob <= 1'b0;
            o_pc        <= '0;
            o_payload   <= '0;
            o_rob_tag   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            o_alloc_rs  <= accept ? sel_onehot : '0;
            o_alloc_rob <= accept;
            if (accept) begin
                o_pc      <= i_pc;
                o_payload <= i_payload;
                o_rob_tag <= tail;
            end
        end
    end

    // Credit, occupancy and tail bookkeeping. Flush overrides frees/commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the credit array is control state, not a data store, so
            // it must be reset like any other counter.
            for (int k = 0; k < NUM_RS; k++) credits[k] <= CRED_MAX;
            rob_count <= '0;
            tail      <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < NUM_RS; k++) credits[k] <= CRED_MAX;
            rob_count <= '0;
            tail      <= '0;
        end else begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (cred_inc[k] && !cred_dec[k])
                    credits[k] <= credits[k] + CRED_W'(1);
                else if (cred_dec[k] && !cred_inc[k])
                    credits[k] <= credits[k] - CRED_W'(1);
            end
            if (accept && !commit_ok)
                rob_count <= rob_count + (TAG_W + 1)'(1);
            else if (commit_ok && !accept)
                rob_count <= rob_count - (TAG_W + 1)'(1);
            // ROB_DEPTH is a power of two, so the tail wraps naturally.
            if (accept)
                tail <= tail + TAG_W'(1);
        end
    end

endmodule

// File: tb/tb_dispatch_credit_router.sv
// tb_dispatch_credit_router
//   Directed scenarios followed by randomized traffic, all checked against a
//   cycle-level reference model built from credit/occupancy arithmetic.

module tb_dispatch_credit_router;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_rs_sel;
    logic [8:0]  i_pc;
    logic [63:0] i_payload;
    logic [2:0]  i_rs_free;
    logic        i_rob_commit;
    logic        i_flush;
    logic [2:0]  o_alloc_rs;
    logic        o_alloc_rob;
    logic [8:0]  o_pc;
    logic [63:0] o_payload;
    logic [3:0]  o_rob_tag;
    logic [4:0]  o_rob_count;
    logic        o_illegal;

    dispatch_credit_router dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_rs_sel     (i_rs_sel),
        .i_pc         (i_pc),
        .i_payload    (i_payload),
        .i_rs_free    (i_rs_free),
        .i_rob_commit (i_rob_commit),
        .i_flush      (i_flush),
        .o_alloc_rs   (o_alloc_rs),
        .o_alloc_rob  (o_alloc_rob),
        .o_pc         (o_pc),
        .o_payload    (o_payload),
        .o_rob_tag    (o_rob_tag),
        .o_rob_count  (o_rob_count),
        .o_illegal    (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_cred [3];
    int          m_rob;
    int          m_tail;
    logic [2:0]  m_rs;
    logic        m_rob_s;
    logic [8:0]  m_pc;
    logic [63:0] m_pl;
    logic [3:0]  m_tag;
    logic        last_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_cred[k] = 8;
        m_rob   = 0;
        m_tail  = 0;
        m_rs    = '0;
        m_rob_s = 1'b0;
        m_pc    = '0;
        m_pl    = '0;
        m_tag   = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance the
    // model, check registered outputs.
    task automatic cyc(input logic v, input int sel, input logic [8:0] pc,
                       input logic [63:0] pl, input logic [2:0] fr,
                       input logic cm, input logic fl);
        logic exp_rdy;
        logic acc;
        int   d;
        i_valid      = v;
        i_rs_sel     = sel[1:0];
        i_pc         = pc;
        i_payload    = pl;
        i_rs_free    = fr;
        i_rob_commit = cm;
        i_flush      = fl;
        #1;
        exp_rdy = !fl && (sel < 3) && ((sel < 3) ? (m_cred[sel] > 0) : 1'b0) && (m_rob < 16);
        check("ready", {63'd0, o_ready}, {63'd0, exp_rdy});
        check("illegal", {63'd0, o_illegal}, {63'd0, v && (sel >= 3)});
        last_rdy = o_ready;
        acc = v && exp_rdy;
        @(posedge clk);
        if (fl) begin
            for (int k = 0; k < 3; k++) m_cred[k] = 8;
            m_rob  = 0;
            m_tail = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                d = 0;
                if (fr[k] && m_cred[k] < 8) d++;
                if (acc && sel == k) d--;
                m_cred[k] += d;
            end
            m_rob = m_rob + (acc ? 1 : 0) - ((cm && m_rob > 0) ? 1 : 0);
        end
        m_rs    = acc ? 3'(1 << sel) : 3'b000;
        m_rob_s = acc;
        if (acc) begin
            m_pc   = pc;
            m_pl   = pl;
            m_tag  = 4'(m_tail);
            m_tail = (m_tail + 1) % 16;
        end
        #1;
        check("alloc_rs", {61'd0, o_alloc_rs}, {61'd0, m_rs});
        check("alloc_rob", {63'd0, o_alloc_rob}, {63'd0, m_rob_s});
        check("pc", {55'd0, o_pc}, {55'd0, m_pc});
        check("payload", o_payload, m_pl);
        check("rob_tag", {60'd0, o_rob_tag}, {60'd0, m_tag});
        check("rob_count", {59'd0, o_rob_count}, 64'(m_rob));
    endtask

    task automatic idle(input logic cm, input logic fl);
        cyc(1'b0, 0, 9'd0, 64'd0, 3'b000, cm, fl);
    endtask

    initial begin
        logic [4:0]  cnt_before;
        logic        h_v;
        int          h_sel;
        logic [8:0]  h_pc;
        logic [63:0] h_pl;
        logic        prev_fl;

        rst = 1'b1; i_valid = 0; i_rs_sel = 0; i_pc = 0; i_payload = 0;
        i_rs_free = 0; i_rob_commit = 0; i_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_alloc_rs", {61'd0, o_alloc_rs}, 64'd0);
        check("rst_alloc_rob", {63'd0, o_alloc_rob}, 64'd0);
        check("rst_tag", {60'd0, o_rob_tag}, 64'd0);
        check("rst_count", {59'd0, o_rob_count}, 64'd0);
        check("rst_pc", {55'd0, o_pc}, 64'd0);
        check("rst_payload", o_payload, 64'd0);

        // ADDI, LW, BEQ, ADD back-to-back
        cyc(1, 0, 9'h010, 64'h0000_0000_ADD1_0001, 3'b000, 0, 0);
        check("seq_addi_rs", {61'd0, o_alloc_rs}, 64'b001);
        cyc(1, 2, 9'h014, 64'h0000_0000_0001_0002, 3'b000, 0, 0);
        check("seq_lw_rs", {61'd0, o_alloc_rs}, 64'b100);
        cyc(1, 1, 9'h018, 64'h0000_0000_0BE0_0003, 3'b000, 0, 0);
        check("seq_beq_rs", {61'd0, o_alloc_rs}, 64'b010);
        cyc(1, 0, 9'h01C, 64'h0000_0000_0ADD_0004, 3'b000, 0, 0);
        check("seq_add_rs", {61'd0, o_alloc_rs}, 64'b001);
        check("seq_add_tag", {60'd0, o_rob_tag}, 64'd3);
        check("seq_count4", {59'd0, o_rob_count}, 64'd4);

        // RS0 credit exhaustion and refill
        idle(0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 9'(32 + i), 64'(i), 3'b000, 0, 0);
        cyc(1, 0, 9'h0AA, 64'hAAAA, 3'b001, 0, 0);
        check("rs0_full_stall", {63'd0, last_rdy}, 64'd0);
        cyc(1, 0, 9'h0AA, 64'hAAAA, 3'b000, 0, 0);
        check("rs0_refill_tag8", {60'd0, o_rob_tag}, 64'd8);
        check("rs0_refill_rs", {61'd0, o_alloc_rs}, 64'b001);

        // ROB full, commit, tag wrap
        idle(0, 1);
        for (int i = 0; i < 16; i++)
            cyc(1, i % 2, 9'(64 + i), 64'(100 + i), (i > 0) ? 3'(1 << ((i - 1) % 2)) : 3'b000, 0, 0);
        cyc(1, 0, 9'h0BB, 64'hBBBB, 3'b010, 0, 0);
        check("rob_full_stall", {63'd0, last_rdy}, 64'd0);
        check("rob_full_count", {59'd0, o_rob_count}, 64'd16);
        cyc(1, 0, 9'h0BB, 64'hBBBB, 3'b000, 1, 0);
        cyc(1, 0, 9'h0BB, 64'hBBBB, 3'b000, 0, 0);
        check("rob_wrap_tag0", {60'd0, o_rob_tag}, 64'd0);
        check("rob_wrap_rob", {63'd0, o_alloc_rob}, 64'd1);

        // Same-cycle take+free on RS1 at credit 3, then accept+commit
        idle(0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 9'(i), 64'(i), 3'b000, 0, 0);
        cyc(1, 1, 9'h055, 64'h55, 3'b010, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 9'(i), 64'(i), 3'b000, 0, 0);
        cyc(1, 1, 9'h066, 64'h66, 3'b000, 0, 0);
        check("rs1_same_cycle_stall", {63'd0, last_rdy}, 64'd0);
        cnt_before = o_rob_count;
        cyc(1, 0, 9'h077, 64'h77, 3'b000, 1, 0);
        check("acc_commit_count", {59'd0, o_rob_count}, {59'd0, cnt_before});

        // Flush with rob_count=5 and credits {2,8,6}
        idle(0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 9'(i), 64'(i), 3'b000, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 2, 9'(i), 64'(i), 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) idle(1, 0);
        check("preflush_count5", {59'd0, o_rob_count}, 64'd5);
        idle(0, 1);
        check("flush_count0", {59'd0, o_rob_count}, 64'd0);
        cyc(1, 2, 9'h1F0, 64'hF0F0, 3'b000, 0, 0);
        check("flush_tag0", {60'd0, o_rob_tag}, 64'd0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 9'(i), 64'(i), 3'b000, 0, 0);

        // Saturation: free at full credit and commit at empty are ignored
        idle(0, 1);
        cyc(0, 0, 9'd0, 64'd0, 3'b111, 1, 0);
        check("commit_at_zero", {59'd0, o_rob_count}, 64'd0);
        for (int i = 0; i < 9; i++) cyc(1, 1, 9'(i), 64'(i), 3'b000, 0, 0);
        check("rs1_sat_stall", {63'd0, last_rdy}, 64'd0);

        // Illegal channel
        cyc(1, 3, 9'h1AB, 64'hDEAD, 3'b000, 0, 0);
        check("illegal_no_strobe", {61'd0, o_alloc_rs}, 64'd0);

        // Reset mid-stream drops the pending strobe immediately
        cyc(1, 2, 9'h0CC, 64'hCCCC, 3'b000, 0, 0);
        rst = 1'b1;
        #1;
        check("midrst_alloc_rs", {61'd0, o_alloc_rs}, 64'd0);
        check("midrst_alloc_rob", {63'd0, o_alloc_rob}, 64'd0);
        check("midrst_pc", {55'd0, o_pc}, 64'd0);
        check("midrst_count", {59'd0, o_rob_count}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Randomized traffic
        h_v = 0; h_sel = 0; h_pc = 0; h_pl = 0; prev_fl = 0; last_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            logic [2:0] fr;
            logic       cm;
            logic       fl;
            if (!(h_v && !last_rdy && h_sel < 3 && !prev_fl)) begin
                h_v   = ($urandom_range(0, 3) != 0);
                h_sel = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                h_pc  = 9'($urandom);
                h_pl  = {$urandom, $urandom};
            end
            fr = '0;
            for (int k = 0; k < 3; k++)
                if (m_cred[k] < 8 && $urandom_range(0, 2) == 0) fr[k] = 1'b1;
            cm = (m_rob > 0) && ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 49) == 0);
            cyc(h_v, h_sel, h_pc, h_pl, fr, cm, fl);
            prev_fl = fl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
